// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//
// Main control FSM for a multicycle MIPS datapath. It steps each instruction
// through fetch, decode, execute, memory and writeback, sharing one memory,
// one ALU, the PC/IR registers and the immediate path. Memory accesses
// (instruction fetch, load, store) hold their state until mem_ready.
//
// Optional feature macro: MC_CTRL_TRAP_EN
//   Defined   - undefined opcodes go through TRAP (PC <- trap vector) and set
//               a sticky illegal_op flag.
//   Undefined - undefined opcodes return to FETCH with no side effects and
//               the illegal_op port is absent.
//
// Parameters:
//   STATE_W   - width of the state register and state_dbg
//   FETCH_INC - 1: PC+4 committed in FETCH, 0: PC write held off in FETCH
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   opcode[5:0]    IR[31:26], stable from DECODE until the next FETCH
//   zero           ALU zero flag (consumed by the datapath with pc_write_cond)
//   mem_ready      memory completes its access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by zero
//   i_or_d         memory address select: 0 PC, 1 ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       IR load
//   reg_dst        register destination: 1 rd, 0 rt
//   mem_to_reg     writeback source: 1 MDR, 0 ALUOut
//   reg_write      register file write
//   alu_src_a      ALU A: 0 PC, 1 A
//   alu_src_b[1:0] ALU B: 00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   alu_op[1:0]    00 add, 01 sub, 10 funct, 11 logic-imm
//   ext_zero       1 zero-extend imm, 0 sign-extend
//   pc_source[1:0] 00 ALU, 01 ALUOut, 10 jump target, 11 trap vector
//   illegal_op     sticky undefined-opcode flag (MC_CTRL_TRAP_EN only)
//   state_dbg      current state code
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int STATE_W   = 4,
    parameter bit FETCH_INC = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               ext_zero,
    output logic [1:0]         pc_source,
`ifdef MC_CTRL_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEM_ADDR = STATE_W'(2),
        S_MEM_RD   = STATE_W'(3),
        S_MEM_WB   = STATE_W'(4),
        S_MEM_WR   = STATE_W'(5),
        S_R_EXEC   = STATE_W'(6),
        S_R_WB     = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_JUMP     = STATE_W'(9),
        S_I_EXEC   = STATE_W'(10),
        S_I_WB     = STATE_W'(11),
        S_TRAP     = STATE_W'(12)
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_isRType;
    logic w_isLw;
    logic w_isSw;
    logic w_isBeq;
    logic w_isJump;
    logic w_isAddi;
    logic w_isLogicImm;
    logic w_unusedZero;

    // The zero flag is combined with pc_write_cond in the datapath, so the
    // FSM itself never looks at it.
    assign w_unusedZero = zero;

    // Opcode classes used by the decode and execute states.
    assign w_isRType    = (opcode == 6'b000000);
    assign w_isLw       = (opcode == 6'b100011);
    assign w_isSw       = (opcode == 6'b101011);
    assign w_isBeq      = (opcode == 6'b000100);
    assign w_isJump     = (opcode == 6'b000010);
    assign w_isAddi     = (opcode == 6'b001000);
    assign w_isLogicImm = (opcode == 6'b001100) || (opcode == 6'b001101);

    assign state_dbg = r_state;

    // State register; reset returns to FETCH from anywhere, abandoning any
    // access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef MC_CTRL_TRAP_EN
    logic r_illegalOp;

    // Sticky flag, set on the edge that enters TRAP so it reads 1 while in
    // TRAP and stays set until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegalOp <= 1'b0;
        end else if (w_next == S_TRAP) begin
            r_illegalOp <= 1'b1;
        end
    end

    assign illegal_op = r_illegalOp;
`endif

    // Next-state and Moore-style output decode. Only FETCH looks at
    // mem_ready for its strobes, so the IR/PC are loaded on the cycle the
    // fetch completes. Every output defaults to 0.
    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        ext_zero      = 1'b0;
        pc_source     = 2'b00;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready & FETCH_INC;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode decodes.
                alu_src_b = 2'b11;
                if (w_isRType) begin
                    w_next = S_R_EXEC;
                end else if (w_isLw || w_isSw) begin
                    w_next = S_MEM_ADDR;
                end else if (w_isBeq) begin
                    w_next = S_BRANCH;
                end else if (w_isJump) begin
                    w_next = S_JUMP;
                end else if (w_isAddi || w_isLogicImm) begin
                    w_next = S_I_EXEC;
                end else begin
`ifdef MC_CTRL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = w_isLw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                w_next    = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                w_next    = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = w_isLogicImm ? 2'b11 : 2'b00;
                ext_zero  = w_isLogicImm;
                w_next    = S_I_WB;
            end
            S_I_WB: begin
                // ALU controls stay as in I_EXEC so ALUOut is not disturbed.
                reg_write = 1'b1;
                alu_op    = w_isLogicImm ? 2'b11 : 2'b00;
                ext_zero  = w_isLogicImm;
                w_next    = S_FETCH;
            end
            S_TRAP: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle main-control FSM for the MIPS datapath. Sequences instruction fetch, decode, execute, memory and writeback over shared resources: a single memory, one ALU, PC/IR registers and the immediate path. Selects sign- vs zero-extended immediate and the shifted immediate. Supports memory wait states through a ready handshake.

Parameters:
STATE_W, 4, width of state register and state_dbg port
FETCH_INC, 1, 1 = PC+4 committed in FETCH; 0 = PC write suppressed in FETCH (bring-up only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag, used in BRANCH
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
i_or_d  out  1  0 = PC address, 1 = ALUOut address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct, 11 logic-imm (funct from opcode)
ext_zero  out  1  1 = zero-extend imm (andi/ori), 0 = sign-extend
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 trap vector
state_dbg  out  STATE_W  current state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, port rst_n. On any rising clk edge with rst_n=0, state <= FETCH. This applies mid-instruction: an in-progress access is abandoned and no write strobe is issued in the following cycle.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12. Codes 13–15 go to FETCH.
- Outputs are decoded combinationally from state. pc_write and ir_write in FETCH additionally depend on mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00.
  - ir_write = mem_ready; pc_write = mem_ready & FETCH_INC.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: 000000→R_EXEC; 100011 or 101011→MEM_ADDR; 000100→BRANCH; 000010→JUMP; 001000, 001100, 001101→I_EXEC; other→FETCH (see feature).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_zero=0. Go to MEM_RD if lw, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH. mem_write stays high across wait cycles.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
- JUMP: pc_write=1, pc_source=10. Go to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10.
  - addi: alu_op=00, ext_zero=0.
  - andi/ori: alu_op=11, ext_zero=1.
  - Go to I_WB.
- I_WB: reg_write=1, reg_dst=0. ext_zero and alu_op hold their I_EXEC values. Go to FETCH.
- Opcode is sampled directly each cycle; the IR guarantees it is stable from DECODE until the next FETCH.
- Latency in cycles at zero wait states: R=4, lw=5, sw=4, beq=3, j=3, addi/andi/ori=4. Each mem_ready=0 cycle adds one cycle.
- Never assert mem_read and mem_write together. Never assert reg_write outside the WB states.

Optional Feature:
- Macro: MC_CTRL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to TRAP. TRAP asserts pc_write=1 and pc_source=11, then goes to FETCH. A sticky output illegal_op (1 bit, reset 0) sets in TRAP and clears only on reset.
- Undefined: undefined opcodes go to FETCH with no side effects. TRAP is unreachable, pc_source never equals 11, and the illegal_op port is absent.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-MEM_WR → state_dbg=0, mem_write=0 in the first cycle after release, mem_read=1.
- lw, opcode 100011, mem_ready always 1 → states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEM_WR → mem_write high for 4 consecutive cycles. No reg_write; return to FETCH.
- beq, opcode 000100: zero=1 → pc_write_cond=1 and pc_source=01 in BRANCH. Repeat with zero=0 → same strobes; 3-cycle sequence.
- andi 001100 → ext_zero=1 and alu_op=11 in I_EXEC and I_WB. addi 001000 → ext_zero=0 and alu_op=00.
- Opcode 111111 → with MC_CTRL_TRAP_EN: DECODE→TRAP→FETCH, pc_source=11, illegal_op=1. Without it: DECODE→FETCH, all strobes 0.
